// File: rtl/audio_spi_arbiter.sv
// Round-robin arbiter sharing the codec SPI register port among NUM_REQ requesters.
// Formats {addr, rw, data} command words, waits for done/timeout, then enforces a CS-high gap.
module audio_spi_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 8192,
  parameter int GAP_CYC     = 64
) (
  input  logic                   iCLK_50,
  input  logic                   iRESET_n,
  input  logic [NUM_REQ-1:0]     iREQ,
  input  logic [NUM_REQ-1:0]     iREQ_RD,
  input  logic [7*NUM_REQ-1:0]   iREQ_ADDR,
  input  logic [8*NUM_REQ-1:0]   iREQ_WDATA,
  output logic [NUM_REQ-1:0]     oGNT,
  output logic [NUM_REQ-1:0]     oACK,
  output logic                   oACK_ERR,
  output logic [7:0]             oRDATA,
  output logic                   oSPI_START,
  output logic [15:0]            oSPI_WORD,
  input  logic                   iSPI_DONE,
  input  logic [7:0]             iSPI_RDATA,
  output logic                   oBUSY,
  output logic [7:0]             oTIMEOUT_CNT
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int GW = $clog2(GAP_CYC) + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 ack_err_q, ack_err_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 start_q, start_d;
  logic [15:0]          word_q, word_d;
  logic                 busy_q, busy_d;
  logic [7:0]           tcnt_q, tcnt_d;

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        cand;
  logic                 win_rd;
  logic [6:0]           win_addr;
  logic [7:0]           win_wdata;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && iREQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end else begin
        win_found = win_found;
      end
    end
    win_rd    = iREQ_RD[win_idx];
    win_addr  = iREQ_ADDR[int'(win_idx)*7 +: 7];
    win_wdata = iREQ_WDATA[int'(win_idx)*8 +: 8];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    ack_err_d = 1'b0;
    rdata_d   = rdata_q;
    start_d   = 1'b0;
    word_d    = word_q;
    tcnt_d    = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ISSUE;
          last_d  = win_idx;
          start_d = 1'b1;
          gnt_d   = ONE_HOT0 << win_idx;
          word_d  = {win_addr, win_rd, (win_rd ? 8'hFF : win_wdata)};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // Done wins over a timeout landing on the same cycle.
        if (iSPI_DONE) begin
          ack_d   = gnt_q;
          rdata_d = word_q[8] ? iSPI_RDATA : 8'h00;
          gnt_d   = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          ack_d     = gnt_q;
          ack_err_d = 1'b1;
          rdata_d   = 8'h00;
          tcnt_d    = (tcnt_q != 8'hFF) ? (tcnt_q + 8'd1) : tcnt_q;
          gnt_d     = '0;
          gap_d     = '0;
          state_d   = S_GAP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; LAST resets so requester 0 wins first.
  always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
    if (!iRESET_n) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(NUM_REQ - 1);
      tmo_q     <= '0;
      gap_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      rdata_q   <= 8'h00;
      start_q   <= 1'b0;
      word_q    <= 16'h0000;
      busy_q    <= 1'b0;
      tcnt_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign oGNT         = gnt_q;
  assign oACK         = ack_q;
  assign oACK_ERR     = ack_err_q;
  assign oRDATA       = rdata_q;
  assign oSPI_START   = start_q;
  assign oSPI_WORD    = word_q;
  assign oBUSY        = busy_q;
  assign oTIMEOUT_CNT = tcnt_q;

endmodule

// File: tb/tb_audio_spi_arbiter.sv
// Directed bench for audio_spi_arbiter with hand-computed expectations.
// Timeout is shortened so that 256 back-to-back timeouts fit in a short run.
module tb_audio_spi_arbiter;

  localparam int NR = 3;
  localparam int TO = 100;
  localparam int GP = 64;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req, req_rd;
  logic [7*NR-1:0] req_addr;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0]   gnt, ack;
  logic            ack_err, spi_start, spi_done, busy;
  logic [7:0]      rdata, spi_rdata, tcnt;
  logic [15:0]     spi_word;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start;

  audio_spi_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO), .GAP_CYC(GP)) dut (
    .iCLK_50(clk), .iRESET_n(rst_n), .iREQ(req), .iREQ_RD(req_rd),
    .iREQ_ADDR(req_addr), .iREQ_WDATA(req_wdata), .oGNT(gnt), .oACK(ack),
    .oACK_ERR(ack_err), .oRDATA(rdata), .oSPI_START(spi_start),
    .oSPI_WORD(spi_word), .iSPI_DONE(spi_done), .iSPI_RDATA(spi_rdata),
    .oBUSY(busy), .oTIMEOUT_CNT(tcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count for measuring start spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic rd, input logic [6:0] a, input logic [7:0] d);
    req_rd[k]          = rd;
    req_addr[7*k +: 7]  = a;
    req_wdata[8*k +: 8] = d;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (spi_start !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check_eq({tag, "_start_bound"}, 32'(spi_start), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check_eq({tag, "_idle_bound"}, 32'(busy), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_gnt"},   32'(gnt), 32'd0);
    check_eq({tag, "_ack"},   32'(ack), 32'd0);
    check_eq({tag, "_err"},   32'(ack_err), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rdata), 32'd0);
    check_eq({tag, "_start"}, 32'(spi_start), 32'd0);
    check_eq({tag, "_word"},  32'(spi_word), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_tcnt"},  32'(tcnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
    spi_done = 1'b0; spi_rdata = 8'h00;
    step();
    step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    // Single write from requester 1, done 20 cycles after start.
    set_req(1, 1'b0, 7'h12, 8'hA5);
    req = 3'b010;
    step();
    check_eq("wr_start", 32'(spi_start), 32'd1);
    check_eq("wr_gnt",   32'(gnt), 32'h2);
    check_eq("wr_word",  32'(spi_word), 32'h24A5);
    check_eq("wr_busy",  32'(busy), 32'd1);
    req = 3'b000;
    step();
    check_eq("wr_start_pulse", 32'(spi_start), 32'd0);
    check_eq("wr_gnt_wait",    32'(gnt), 32'h2);
    repeat (18) step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    check_eq("wr_ack",   32'(ack), 32'h2);
    check_eq("wr_err",   32'(ack_err), 32'd0);
    check_eq("wr_rdata", 32'(rdata), 32'h00);
    check_eq("wr_gnt_gap", 32'(gnt), 32'h0);
    for (int i = 0; i < GP - 1; i++) begin
      spi_done = (i == 9);
      step();
    end
    spi_done = 1'b0;
    check_eq("gap_stray_ack", 32'(ack), 32'd0);
    check_eq("gap_busy_63",   32'(busy), 32'd1);
    step();
    check_eq("gap_idle_64",   32'(busy), 32'd0);

    // Read from requester 2; fields changed after selection must not matter.
    set_req(2, 1'b1, 7'h23, 8'h00);
    req = 3'b100;
    step();
    check_eq("rd_start", 32'(spi_start), 32'd1);
    check_eq("rd_gnt",   32'(gnt), 32'h4);
    check_eq("rd_word",  32'(spi_word), 32'h47FF);
    req = 3'b000;
    set_req(2, 1'b0, 7'h7F, 8'h3C);
    step();
    check_eq("rd_word_hold", 32'(spi_word), 32'h47FF);
    repeat (3) step();
    spi_done = 1'b1; spi_rdata = 8'h01;
    step();
    spi_done = 1'b0; spi_rdata = 8'h00;
    check_eq("rd_ack",   32'(ack), 32'h4);
    check_eq("rd_err",   32'(ack_err), 32'd0);
    check_eq("rd_rdata", 32'(rdata), 32'h01);
    wait_idle("rd");

    // Stray done while idle.
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    check_eq("idle_stray_ack",  32'(ack), 32'd0);
    check_eq("idle_stray_busy", 32'(busy), 32'd0);

    // Timeout: ack with error exactly TO cycles after WAIT entry.
    set_req(0, 1'b0, 7'h01, 8'h02);
    req = 3'b001;
    step();
    check_eq("to_start", 32'(spi_start), 32'd1);
    check_eq("to_word",  32'(spi_word), 32'h0202);
    req = 3'b000;
    repeat (TO) step();
    check_eq("to_early_ack", 32'(ack), 32'd0);
    step();
    check_eq("to_ack",   32'(ack), 32'h1);
    check_eq("to_err",   32'(ack_err), 32'd1);
    check_eq("to_rdata", 32'(rdata), 32'h00);
    check_eq("to_tcnt",  32'(tcnt), 32'd1);
    wait_idle("to");

    // Done on the final timeout cycle counts as success.
    req = 3'b001;
    step();
    check_eq("race_start", 32'(spi_start), 32'd1);
    req = 3'b000;
    repeat (TO) step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    check_eq("race_ack",  32'(ack), 32'h1);
    check_eq("race_err",  32'(ack_err), 32'd0);
    check_eq("race_tcnt", 32'(tcnt), 32'd1);
    wait_idle("race");

    // Reset during WAIT clears everything asynchronously and restores priority.
    req = 3'b001;
    step();
    req = 3'b000;
    step();
    step();
    check_eq("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    step();
    req = 3'b011;
    rst_n = 1'b1;
    step();
    check_eq("post_reset_start", 32'(spi_start), 32'd1);
    check_eq("post_reset_gnt",   32'(gnt), 32'h1);
    req = 3'b000;
    step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    check_eq("post_reset_ack", 32'(ack), 32'h1);
    wait_idle("post_reset");

    // Fairness with all requests held from reset; minimum spacing GP+3.
    rst_n = 1'b0;
    req = 3'b111;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_start("fair");
      check_eq($sformatf("fair_gnt%0d", i), 32'(gnt), 32'(3'b001 << (i % 3)));
      if (i > 0) check_eq($sformatf("fair_space%0d", i), 32'(cyc - last_start), 32'(GP + 3));
      last_start = cyc;
      step();
      spi_done = 1'b1;
      step();
      spi_done = 1'b0;
      check_eq($sformatf("fair_ack%0d", i), 32'(ack), 32'(3'b001 << (i % 3)));
    end
    req = 3'b000;
    wait_idle("fair");

    // Saturating timeout counter over 256 timeouts.
    req = 3'b001;
    for (int i = 0; i < 256; i++) begin
      wait_start("sat");
      repeat (TO + 1) step();
      check_eq($sformatf("sat_ack%0d", i), 32'({ack, ack_err}), 32'h3);
      if (i == 253) check_eq("sat_tcnt254", 32'(tcnt), 32'd254);
      if (i == 254) check_eq("sat_tcnt255", 32'(tcnt), 32'd255);
      if (i == 255) check_eq("sat_tcnt_hold", 32'(tcnt), 32'd255);
    end
    req = 3'b000;
    wait_idle("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
